act_quant_with_mem: RTL and testbench
=====================================

Name: act_quant_with_mem

Overview:
- Post-processing stage downstream of the MAC2 memory engine.
- Reads 32-bit signed accumulator words that the MAC engine wrote into shared memory.
- Applies bias, optional ReLU, arithmetic right shift and int8 saturation to each word.
- Packs four results per 32-bit word and writes them back, producing next-layer activations in the same byte order the MAC engine consumes (element 0 in bits [7:0]).

Parameters:
- ADDR_W, 8, memory address width
- DATA_W, 32, memory word / accumulator width (fixed 4 lanes of 8 bits)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active-low
- start  in  1  one-cycle pulse; latches config and begins a job when idle
- done  out  1  one-cycle pulse at job completion
- busy  out  1  high from the cycle after start until the done cycle inclusive
- src_addr  in  ADDR_W  address of first accumulator word
- dst_addr  in  ADDR_W  address of first packed output word
- count  in  8  number of accumulators (0..255)
- bias  in  32  signed bias added to every accumulator
- shift  in  5  arithmetic right-shift amount
- relu_en  in  1  clamp negative sums to 0 before shift
- mem_w  out  1  memory write enable
- mem_sel  out  1  memory select
- address_bus  inout  ADDR_W  driven only while mem_sel=1, else Z
- data_bus  inout  DATA_W  driven only while mem_sel=1 and mem_w=1, else Z

Behaviour:
- Reset values (rst low, asynchronous): done=0, busy=0, mem_w=0, mem_sel=0, buses Z, FSM=IDLE, packing register=0, indices=0.
- Memory protocol:
  - Read: mem_sel=1, mem_w=0, address driven for one cycle; data_bus is sampled at the following rising edge.
  - Write: mem_sel=1, mem_w=1, address and data driven for one cycle; memory captures them at that edge.
- FSM states: IDLE, RD_REQ, RD_CAP, WR, DONE.
- IDLE:
  - On start, latch src_addr, dst_addr, count, bias, shift and relu_en; clear element index i and packing register.
  - If count=0, go to DONE; else go to RD_REQ.
  - start is ignored in every other state.
- RD_REQ: drive read of (src_addr+i) mod 2^ADDR_W; go to RD_CAP.
- RD_CAP:
  - Memory outputs inactive.
  - Capture data_bus and compute q; place q in lane i[1:0], bits [8*lane+7:8*lane].
  - If lane==3 or i==count-1, go to WR; else increment i and go to RD_REQ.
- WR:
  - Write the packing register to (dst_addr + i>>2) mod 2^ADDR_W; lanes not filled in a partial last word are 0.
  - Clear the packing register.
  - If i==count-1, go to DONE; else increment i and go to RD_REQ.
- DONE: done=1 for exactly one cycle, memory outputs inactive; go to IDLE.
- Latency from the start edge to the done cycle:
  - count>0: 2*count + ceil(count/4) + 1 cycles.
  - count=0: 1 cycle, with no memory access.
- Arithmetic:
  - s = sext33(acc) + sext33(bias), computed with no 32-bit overflow.
  - If relu_en and s<0, s=0.
  - t = s >>> shift (floor, no rounding).
  - q = saturate t to [-128,127], two's complement byte.
- Address wrap: both source and destination addresses wrap modulo 256.
- Reset mid-job: immediate return to reset values. A write in progress is abandoned (not captured if rst is asserted before the edge). No done pulse.
- Bus ownership: the block drives nothing while the MAC engine or the bench owns the bus. System control guarantees mutual exclusion.

Test Plan:
- Single element: memory[0]=70, src=0, dst=8, count=1, bias=0, shift=0, relu=1 -> mem[8]=0x00000046; done 4 cycles after start; exactly 1 write.
- Saturation, no ReLU: mem[0..3]={100,-5,300,-300}, count=4, relu=0 -> mem[dst]=0x807FFB64. Repeat with relu=1 -> 0x007F0064.
- Bias and shift: acc=1000, bias=24, shift=3 -> 0x7F (128 saturates). acc=-17, bias=0, shift=2, relu=0 -> 0xFB (-5). acc=0x7FFFFFFF, bias=1, shift=31 -> 1 (no overflow).
- Partial word and wrap: src=0xFE, count=6, values 1..6, dst=0xFF:
  - reads 0xFE,0xFF,0x00..0x03;
  - writes mem[0xFF]=0x04030201 and mem[0x00]=0x00000605 (the second write overwrites the source word at 0x00 after it was read);
  - done at cycle 15.
- count=0 -> done pulse next cycle; mem_sel never asserted; buses Z throughout.
- Robustness:
  - start pulsed mid-job -> ignored; results unchanged.
  - rst asserted during an RD_CAP of a 4-element job -> outputs return to reset values immediately; no write occurs; no done pulse.
  - A new job after reset runs correctly.

Source files
------------

// File: rtl/act_quant_with_mem.sv
// act_quant_with_mem: requantises int32 accumulators from shared memory into
// packed int8 activations (bias, optional ReLU, arithmetic shift, saturation).
// Ports: clk, rst (async, active-low), start/done/busy job control,
//   src_addr/dst_addr/count/bias/shift/relu_en job config,
//   mem_w/mem_sel plus tri-state address_bus/data_bus memory master.
module act_quant_with_mem #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              done,
  output logic              busy,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [7:0]        count,
  input  logic [31:0]       bias,
  input  logic [4:0]        shift,
  input  logic              relu_en,
  output logic              mem_w,
  output logic              mem_sel,
  inout  wire  [ADDR_W-1:0] address_bus,
  inout  wire  [DATA_W-1:0] data_bus
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] RD_REQ = 3'd1;
  localparam logic [2:0] RD_CAP = 3'd2;
  localparam logic [2:0] WR     = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;

  logic [2:0]        state_q;
  logic [ADDR_W-1:0] src_q;
  logic [ADDR_W-1:0] dst_q;
  logic [7:0]        cnt_q;
  logic [31:0]       bias_q;
  logic [4:0]        shift_q;
  logic              relu_q;
  logic [7:0]        i_q;
  logic [DATA_W-1:0] pack_q;

  logic              last;
  logic [ADDR_W-1:0] addr;
  logic signed [32:0] sum;
  logic signed [32:0] shf;
  logic [7:0]        q;

  assign last = (i_q == cnt_q - 8'd1);

  // 33-bit sum keeps acc+bias exact; floor shift, then clamp to int8.
  always_comb begin
    sum = $signed({data_bus[DATA_W-1], data_bus})
        + $signed({bias_q[31], bias_q});
    if (relu_q && sum[32]) begin
      sum = '0;
    end
    shf = sum >>> shift_q;
    if (shf > 33'sd127) begin
      q = 8'h7f;
    end else if (shf < -33'sd128) begin
      q = 8'h80;
    end else begin
      q = shf[7:0];
    end
  end

  always_comb begin
    mem_sel = (state_q == RD_REQ) || (state_q == WR);
    mem_w   = (state_q == WR);
    busy    = (state_q != IDLE);
    done    = (state_q == DONE);
    if (state_q == WR) begin
      addr = dst_q + ADDR_W'(i_q >> 2);
    end else begin
      addr = src_q + ADDR_W'(i_q);
    end
  end

  assign address_bus = mem_sel ? addr : 'z;
  assign data_bus    = (mem_sel && mem_w) ? pack_q : 'z;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      bias_q  <= '0;
      shift_q <= '0;
      relu_q  <= 1'b0;
      i_q     <= '0;
      pack_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            src_q   <= src_addr;
            dst_q   <= dst_addr;
            cnt_q   <= count;
            bias_q  <= bias;
            shift_q <= shift;
            relu_q  <= relu_en;
            i_q     <= '0;
            pack_q  <= '0;
            state_q <= (count == 8'd0) ? DONE : RD_REQ;
          end
        end
        RD_REQ: begin
          state_q <= RD_CAP;
        end
        RD_CAP: begin
          pack_q[{i_q[1:0], 3'b000} +: 8] <= q;
          if (i_q[1:0] == 2'd3 || last) begin
            state_q <= WR;
          end else begin
            i_q     <= i_q + 8'd1;
            state_q <= RD_REQ;
          end
        end
        WR: begin
          pack_q <= '0;
          if (last) begin
            state_q <= DONE;
          end else begin
            i_q     <= i_q + 8'd1;
            state_q <= RD_REQ;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_act_quant_with_mem.sv
// tb_act_quant_with_mem: bench memory on the shared bus, plus a sequential
// reference model of each job, compared against the DUT every cycle.
module tb_act_quant_with_mem;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        done;
  logic        busy;
  logic [7:0]  src_addr = '0;
  logic [7:0]  dst_addr = '0;
  logic [7:0]  count = '0;
  logic [31:0] bias = '0;
  logic [4:0]  shift = '0;
  logic        relu_en = 1'b0;
  logic        mem_w;
  logic        mem_sel;
  wire  [7:0]  address_bus;
  wire  [31:0] data_bus;

  logic [31:0] mem [256];
  logic [31:0] ref_mem [256];
  logic        rd_valid = 1'b0;
  logic [31:0] rd_data = '0;
  logic        pb_we = 1'b0;
  logic [7:0]  pb_addr = '0;
  logic [31:0] pb_data = '0;

  logic [7:0]  exp_rd [$];
  logic [7:0]  exp_wa [$];
  logic [31:0] exp_wd [$];
  int          rd_pos = 0;
  int          wr_pos = 0;
  bit          active = 1'b0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  act_quant_with_mem #(.ADDR_W(8), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .done(done), .busy(busy),
    .src_addr(src_addr), .dst_addr(dst_addr), .count(count),
    .bias(bias), .shift(shift), .relu_en(relu_en),
    .mem_w(mem_w), .mem_sel(mem_sel),
    .address_bus(address_bus), .data_bus(data_bus)
  );

  assign data_bus = rd_valid ? rd_data : 'z;

  always @(posedge clk) begin
    rd_valid <= 1'b0;
    if (pb_we) begin
      mem[pb_addr] <= pb_data;
    end else if (mem_sel && mem_w) begin
      mem[address_bus] <= data_bus;
    end else if (mem_sel) begin
      rd_valid <= 1'b1;
      rd_data  <= mem[address_bus];
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mem_sel && !mem_w) begin
      if (rd_pos >= exp_rd.size()) begin
        chk("rd_extra", {24'd0, address_bus}, 32'hffff_ffff);
      end else begin
        chk("rd_addr", {24'd0, address_bus}, {24'd0, exp_rd[rd_pos]});
      end
      rd_pos++;
    end
    if (mem_sel && mem_w) begin
      if (wr_pos >= exp_wa.size()) begin
        chk("wr_extra", {24'd0, address_bus}, 32'hffff_ffff);
      end else begin
        chk("wr_addr", {24'd0, address_bus}, {24'd0, exp_wa[wr_pos]});
        chk("wr_data", data_bus, exp_wd[wr_pos]);
      end
      wr_pos++;
    end
    if (!mem_sel && mem_w) begin
      chk("w_without_sel", 32'd1, 32'd0);
    end
    if (!active) begin
      chk("idle_quiet", {29'd0, mem_sel, done, busy}, 32'd0);
    end
  end

  function automatic logic [7:0] qref(input logic [31:0] acc,
                                      input logic [31:0] b,
                                      input int sh, input bit relu);
    longint s;
    s = longint'($signed(acc)) + longint'($signed(b));
    if (relu && s < 0) s = 0;
    s = s >>> sh;
    if (s > 127) return 8'h7f;
    if (s < -128) return 8'h80;
    return s[7:0];
  endfunction

  task automatic poke(input logic [7:0] a, input logic [31:0] d);
    pb_we   = 1'b1;
    pb_addr = a;
    pb_data = d;
    ref_mem[a] = d;
    @(posedge clk);
    #1;
    pb_we = 1'b0;
  endtask

  task automatic run_job(input logic [7:0] src, input logic [7:0] dst,
                         input int cnt, input logic [31:0] b,
                         input int sh, input bit relu, input bit mid,
                         output int lat);
    logic [31:0] word;
    logic [7:0]  a;
    int          exp_lat;
    int          rd0;
    int          wr0;
    int          nmis;
    bit          bad;
    word = '0;
    for (int k = 0; k < cnt; k++) begin
      a = src + 8'(k);
      exp_rd.push_back(a);
      word[8*(k%4) +: 8] = qref(ref_mem[a], b, sh, relu);
      if (k % 4 == 3 || k == cnt - 1) begin
        a = dst + 8'(k / 4);
        exp_wa.push_back(a);
        exp_wd.push_back(word);
        ref_mem[a] = word;
        word = '0;
      end
    end
    exp_lat = (cnt == 0) ? 1 : 2 * cnt + (cnt + 3) / 4 + 1;
    rd0 = exp_rd.size();
    wr0 = exp_wa.size();
    src_addr = src;
    dst_addr = dst;
    count    = 8'(cnt);
    bias     = b;
    shift    = 5'(sh);
    relu_en  = relu;
    start    = 1'b1;
    active   = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    src_addr = 8'($urandom);
    dst_addr = 8'($urandom);
    count    = 8'($urandom);
    bias     = $urandom;
    shift    = 5'($urandom);
    relu_en  = ~relu;
    lat = 1;
    bad = 1'b0;
    while (!done && lat < 2000) begin
      if (!busy) bad = 1'b1;
      start = (mid && lat == 3);
      @(posedge clk);
      #1;
      lat++;
    end
    start = 1'b0;
    chk("done_seen", {31'd0, done}, 32'd1);
    chk("latency", lat, exp_lat);
    chk("busy", {31'd0, busy & ~bad}, 32'd1);
    @(posedge clk);
    #1;
    active = 1'b0;
    chk("done_pulse", {30'd0, done, busy}, 32'd0);
    chk("rd_count", rd_pos, rd0);
    chk("wr_count", wr_pos, wr0);
    nmis = 0;
    for (int k = 0; k < 256; k++) begin
      if (mem[k] !== ref_mem[k]) nmis++;
    end
    chk("mem_image", nmis, 0);
  endtask

  int lat;
  int w0;
  int sh;
  int cnt;
  logic [7:0] s8;
  logic [7:0] d8;
  logic [31:0] b32;

  initial begin
    for (int k = 0; k < 256; k++) poke(8'(k), 32'h0);
    chk("rst_outputs", {28'd0, done, busy, mem_sel, mem_w}, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    chk("q_bias_shift", {24'd0, qref(32'd1000, 32'd24, 3, 0)}, 32'h7f);
    chk("q_neg_floor", {24'd0, qref(-32'sd17, 32'd0, 2, 0)}, 32'hfb);
    chk("q_no_ovf", {24'd0, qref(32'h7fff_ffff, 32'd1, 31, 1)}, 32'h01);
    chk("q_sat_lo", {24'd0, qref(-32'sd300, 32'd0, 0, 0)}, 32'h80);

    poke(8'h00, 32'd70);
    w0 = wr_pos;
    run_job(8'h00, 8'h08, 1, 32'd0, 0, 1, 0, lat);
    chk("single_word", mem[8'h08], 32'h0000_0046);
    chk("single_lat", lat, 4);
    chk("single_writes", wr_pos - w0, 1);

    poke(8'h00, 32'd100);
    poke(8'h01, -32'sd5);
    poke(8'h02, 32'd300);
    poke(8'h03, -32'sd300);
    run_job(8'h00, 8'h10, 4, 32'd0, 0, 0, 0, lat);
    chk("sat_norelu", mem[8'h10], 32'h807f_fb64);
    run_job(8'h00, 8'h11, 4, 32'd0, 0, 1, 0, lat);
    chk("sat_relu", mem[8'h11], 32'h007f_0064);

    poke(8'h20, 32'd1000);
    run_job(8'h20, 8'h30, 1, 32'd24, 3, 0, 0, lat);
    chk("bias_shift", mem[8'h30], 32'h0000_007f);
    poke(8'h21, -32'sd17);
    run_job(8'h21, 8'h31, 1, 32'd0, 2, 0, 0, lat);
    chk("neg_shift", mem[8'h31], 32'h0000_00fb);
    poke(8'h22, 32'h7fff_ffff);
    run_job(8'h22, 8'h32, 1, 32'd1, 31, 0, 0, lat);
    chk("no_overflow", mem[8'h32], 32'h0000_0001);

    for (int k = 0; k < 6; k++) poke(8'hfe + 8'(k), 32'(k + 1));
    run_job(8'hfe, 8'hff, 6, 32'd0, 0, 0, 0, lat);
    chk("wrap_word0", mem[8'hff], 32'h0403_0201);
    chk("wrap_word1", mem[8'h00], 32'h0000_0605);
    chk("wrap_lat", lat, 15);

    w0 = wr_pos + rd_pos;
    run_job(8'h40, 8'h50, 0, 32'd5, 1, 0, 0, lat);
    chk("zero_lat", lat, 1);
    chk("zero_access", wr_pos + rd_pos - w0, 0);

    for (int k = 0; k < 9; k++) poke(8'h60 + 8'(k), $urandom);
    run_job(8'h60, 8'h70, 9, 32'hffff_ff00, 4, 1, 1, lat);

    for (int k = 0; k < 4; k++) poke(8'h80 + 8'(k), $urandom);
    poke(8'h90, 32'hdead_beef);
    exp_rd.push_back(8'h80);
    src_addr = 8'h80;
    dst_addr = 8'h90;
    count    = 8'd4;
    start    = 1'b1;
    active   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    active = 1'b0;
    chk("rst_midjob", {28'd0, done, busy, mem_sel, mem_w}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    chk("rst_nowrite", mem[8'h90], 32'hdead_beef);
    chk("rst_reads", rd_pos, exp_rd.size());
    run_job(8'h80, 8'h91, 4, 32'd7, 2, 0, 0, lat);

    for (int j = 0; j < 25; j++) begin
      s8  = 8'($urandom);
      d8  = 8'($urandom);
      cnt = $urandom_range(1, 40);
      sh  = $urandom_range(0, 31);
      b32 = ($urandom_range(0, 1) == 1) ? $urandom : 32'($signed(8'($urandom)));
      for (int k = 0; k < cnt; k++) begin
        if ($urandom_range(0, 1) == 1) begin
          poke(s8 + 8'(k), $urandom);
        end else begin
          poke(s8 + 8'(k), 32'($signed(10'($urandom))));
        end
      end
      run_job(s8, d8, cnt, b32, sh, 1'($urandom), 1'($urandom), lat);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
